// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed per-neuron spike counter with sequential argmax and valid/ready result
//
// Counts the spikes from each output neuron over window_len timesteps (one timestep
// per clock), then scans the counts one neuron per cycle to pick the most active
// neuron. The result is held until the consumer accepts it.
//
// Ports:
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   start          request a decode window (sampled only while idle)
//   window_len     number of timesteps to count, sampled with start (0 = ignored)
//   spike_in       one spike bit per neuron, sampled each counting cycle
//   busy           high whenever a window is being counted, scanned or held
//   out_valid      result available; cleared by out_ready
//   out_ready      consumer accepts the result
//   count_flat     neuron i count at [i*CNT_W +: CNT_W]
//   winner         lowest index holding the maximum count
//   tie            another neuron equals the winner's count
//   overflow       at least one counter saturated during the window

module spike_rate_decoder #(
   parameter int N_NEURONS = 4,
   parameter int IDX_W     = 2,
   parameter int CNT_W     = 6,
   parameter int WIN_W     = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [WIN_W-1:0]           window_len,
   input  logic [N_NEURONS-1:0]       spike_in,
   output logic                       busy,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_NEURONS*CNT_W-1:0] count_flat,
   output logic [IDX_W-1:0]           winner,
   output logic                       tie,
   output logic                       overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      SCAN  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t             state, state_next;
   logic [WIN_W-1:0]   remaining;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   best;
   logic [CNT_W-1:0]   count [N_NEURONS];
   logic               accept;

   assign accept = (state == IDLE) && start && (window_len != '0);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (accept)                     state_next = COUNT;
         COUNT: if (remaining == WIN_W'(1))     state_next = SCAN;
         SCAN:  if (idx == LAST_IDX)            state_next = HOLD;
         HOLD:  if (out_ready)                  state_next = IDLE;
         default:                               state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // busy/out_valid follow the next state so they are registered yet line up
   // exactly with the state they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         busy      <= (state_next != IDLE);
         out_valid <= (state_next == HOLD);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         remaining <= '0;
         idx       <= '0;
         best      <= '0;
         winner    <= '0;
         tie       <= 1'b0;
         overflow  <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) count[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  remaining <= window_len;
                  idx       <= '0;
                  overflow  <= 1'b0;
                  tie       <= 1'b0;
                  for (int i = 0; i < N_NEURONS; i++) count[i] <= '0;
               end
            end
            COUNT: begin
               remaining <= remaining - WIN_W'(1);
               for (int i = 0; i < N_NEURONS; i++) begin
                  if (spike_in[i]) begin
                     if (count[i] == CNT_MAX) overflow <= 1'b1;
                     else                     count[i] <= count[i] + CNT_W'(1);
                  end
               end
            end
            SCAN: begin
               if (idx == '0) begin
                  best   <= count[idx];
                  winner <= idx;
                  tie    <= 1'b0;
               end else if (count[idx] > best) begin
                  best   <= count[idx];
                  winner <= idx;
                  tie    <= 1'b0;
               end else if (count[idx] == best) begin
                  // Strictly-greater replacement keeps the lowest index on ties.
                  tie    <= 1'b1;
               end
               idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < N_NEURONS; g++) begin : g_flat
      assign count_flat[g*CNT_W +: CNT_W] = count[g];
   end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - self-checking bench for spike_rate_decoder

module tb_spike_rate_decoder;

   localparam int N  = 4;
   localparam int CW = 6;
   localparam int WW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [WW-1:0] window_len;
   logic [N-1:0]  spike_in;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [N*CW-1:0] count_flat;
   logic [1:0]    winner;
   logic          tie;
   logic          overflow;

   int tests_run = 0;
   int tests_failed = 0;

   logic [N-1:0]    spikes [0:255];
   logic [N*CW-1:0] exp_flat;
   int              exp_win;
   bit              exp_tie;
   bit              exp_ovf;
   int              lat;
   bit              busy_at_start;

   spike_rate_decoder #(.N_NEURONS(N), .IDX_W(2), .CNT_W(CW), .WIN_W(WW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .window_len(window_len),
      .spike_in(spike_in), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .count_flat(count_flat), .winner(winner), .tie(tie), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference: plain sums, clamp, first max index, any other equal to the max.
   task automatic model(input int w);
      int sums [N];
      int mx;
      for (int i = 0; i < N; i++) sums[i] = 0;
      for (int t = 0; t < w; t++)
         for (int i = 0; i < N; i++) sums[i] += spikes[t][i];
      exp_ovf = 0;
      for (int i = 0; i < N; i++) begin
         if (sums[i] > CMAX) begin exp_ovf = 1; sums[i] = CMAX; end
         exp_flat[i*CW +: CW] = CW'(sums[i]);
      end
      mx = -1;
      for (int i = 0; i < N; i++) if (sums[i] > mx) begin mx = sums[i]; exp_win = i; end
      exp_tie = 0;
      for (int i = 0; i < N; i++) if (i != exp_win && sums[i] == mx) exp_tie = 1;
   endtask

   // Called #1 after an edge; start is accepted on the next edge (E0).
   // lat = edges after E0 until out_valid seen, -1 on timeout.
   task automatic drive_window(input int w);
      start = 1'b1;
      window_len = WW'(w);
      @(posedge clk); #1;
      start = 1'b0;
      busy_at_start = busy;
      for (int t = 0; t < w; t++) begin
         spike_in = spikes[t];
         @(posedge clk); #1;
      end
      spike_in = '0;
      lat = w;
      while (!out_valid && lat < w + 50) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      tests_run++;
      if ({busy, out_valid, count_flat, winner, tie, overflow} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h required 0", {busy, out_valid, count_flat, winner, tie, overflow});
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      for (int t = 0; t < 10; t++) spikes[t] = {1'b0, 1'b1, 1'b0, (t % 2 == 0)};
      drive_window(10);
      tests_run++;
      if (lat != 14) begin tests_failed++; $display("FAIL basic_latency: got %0d required 14", lat); end
      tests_run++;
      if (count_flat !== {6'd0, 6'd10, 6'd0, 6'd5}) begin
         tests_failed++; $display("FAIL basic_counts: got %h required %h", count_flat, {6'd0, 6'd10, 6'd0, 6'd5});
      end
      tests_run++;
      if (winner !== 2'd2 || tie !== 1'b0 || overflow !== 1'b0) begin
         tests_failed++; $display("FAIL basic_decision: got w=%0d t=%0d o=%0d required w=2 t=0 o=0", winner, tie, overflow);
      end
      tests_run++;
      if (busy_at_start !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %0d required 1", busy_at_start); end
      handshake();
   endtask

   task automatic test_tie();
      for (int t = 0; t < 12; t++) spikes[t] = {(t % 2 == 0), 1'b0, (t % 2 == 0), (t == 1 || t == 3)};
      drive_window(12);
      tests_run++;
      if (lat != 16 || winner !== 2'd1 || tie !== 1'b1 || count_flat !== {6'd6, 6'd0, 6'd6, 6'd2}) begin
         tests_failed++;
         $display("FAIL tie_pair: got lat=%0d w=%0d t=%0d c=%h required lat=16 w=1 t=1 c=%h", lat, winner, tie, count_flat, {6'd6, 6'd0, 6'd6, 6'd2});
      end
      handshake();
      for (int t = 0; t < 5; t++) spikes[t] = '0;
      drive_window(5);
      tests_run++;
      if (count_flat !== '0 || winner !== 2'd0 || tie !== 1'b1) begin
         tests_failed++; $display("FAIL tie_all_zero: got c=%h w=%0d t=%0d required c=0 w=0 t=1", count_flat, winner, tie);
      end
      handshake();
   endtask

   task automatic test_saturation();
      for (int t = 0; t < 100; t++) spikes[t] = 4'b0001;
      drive_window(100);
      tests_run++;
      if (count_flat[CW-1:0] !== 6'd63 || overflow !== 1'b1 || winner !== 2'd0 || lat != 104) begin
         tests_failed++;
         $display("FAIL saturate: got c0=%0d o=%0d w=%0d lat=%0d required c0=63 o=1 w=0 lat=104", count_flat[CW-1:0], overflow, winner, lat);
      end
      handshake();
      tests_run++;
      if (overflow !== 1'b1) begin tests_failed++; $display("FAIL overflow_kept_after_ack: got %0d required 1", overflow); end
      for (int t = 0; t < 3; t++) spikes[t] = '0;
      drive_window(3);
      tests_run++;
      if (overflow !== 1'b0) begin tests_failed++; $display("FAIL overflow_cleared: got %0d required 0", overflow); end
      handshake();
   endtask

   task automatic test_backpressure();
      logic [N*CW+3:0] snap;
      for (int t = 0; t < 7; t++) spikes[t] = 4'($urandom);
      model(7);
      drive_window(7);
      snap = {count_flat, winner, tie, overflow};
      tests_run++;
      if (lat != 11 || snap !== {exp_flat, 2'(exp_win), exp_tie, exp_ovf}) begin
         tests_failed++; $display("FAIL bp_result: got lat=%0d r=%h required lat=11 r=%h", lat, snap, {exp_flat, 2'(exp_win), exp_tie, exp_ovf});
      end
      for (int c = 0; c < 20; c++) begin
         start = (c == 5 || c == 6);
         window_len = 8'd5;
         spike_in = 4'hF;
         @(posedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || busy !== 1'b1 || {count_flat, winner, tie, overflow} !== snap) begin
            tests_failed++;
            $display("FAIL bp_hold_c%0d: got v=%0d b=%0d r=%h required v=1 b=1 r=%h", c, out_valid, busy, {count_flat, winner, tie, overflow}, snap);
         end
      end
      start = 1'b0;
      spike_in = '0;
      handshake();
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || {count_flat, winner, tie, overflow} !== snap) begin
         tests_failed++; $display("FAIL bp_ack: got v=%0d b=%0d required v=0 b=0 with result kept", out_valid, busy);
      end
      for (int t = 0; t < 4; t++) spikes[t] = 4'b1000;
      drive_window(4);
      tests_run++;
      if (busy_at_start !== 1'b1 || lat != 8 || winner !== 2'd3 || count_flat !== {6'd4, 18'd0}) begin
         tests_failed++; $display("FAIL bp_restart: got b=%0d lat=%0d w=%0d required b=1 lat=8 w=3", busy_at_start, lat, winner);
      end
      handshake();
   endtask

   task automatic test_reset_mid_count();
      for (int t = 0; t < 10; t++) spikes[t] = 4'hF;
      start = 1'b1;
      window_len = 8'd10;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 0; t < 3; t++) begin
         spike_in = spikes[t];
         @(posedge clk); #1;
      end
      #2;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, out_valid, count_flat, winner, tie, overflow} !== '0) begin
         tests_failed++; $display("FAIL reset_mid_count: got %h required 0", {busy, out_valid, count_flat, winner, tie, overflow});
      end
      spike_in = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int t = 0; t < 3; t++) spikes[t] = 4'($urandom);
      model(3);
      drive_window(3);
      tests_run++;
      if (lat != 7 || count_flat !== exp_flat || winner !== 2'(exp_win) || tie !== exp_tie) begin
         tests_failed++; $display("FAIL reset_fresh_run: got lat=%0d c=%h w=%0d required lat=7 c=%h w=%0d", lat, count_flat, winner, exp_flat, exp_win);
      end
      handshake();
   endtask

   task automatic test_zero_window();
      int seen;
      seen = 0;
      start = 1'b1;
      window_len = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (busy || out_valid) seen++;
         @(posedge clk); #1;
      end
      tests_run++;
      if (seen != 0) begin tests_failed++; $display("FAIL zero_window: got %0d active cycles required 0", seen); end
   endtask

   task automatic test_random();
      int w;
      for (int r = 0; r < 12; r++) begin
         w = (r < 4) ? $urandom_range(60, 120) : $urandom_range(1, 40);
         for (int t = 0; t < w; t++)
            spikes[t] = (r < 4) ? (4'($urandom) | 4'($urandom)) : 4'($urandom);
         model(w);
         drive_window(w);
         tests_run++;
         if (lat != w + N || count_flat !== exp_flat || winner !== 2'(exp_win) || tie !== exp_tie || overflow !== exp_ovf) begin
            tests_failed++;
            $display("FAIL random_%0d: got lat=%0d c=%h w=%0d t=%0d o=%0d required lat=%0d c=%h w=%0d t=%0d o=%0d",
                     r, lat, count_flat, winner, tie, overflow, w + N, exp_flat, exp_win, exp_tie, exp_ovf);
         end
         handshake();
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      window_len = '0;
      spike_in = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_tie();
      test_saturation();
      test_backpressure();
      test_reset_mid_count();
      test_zero_window();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
